// File: rtl/fall_ctrl.sv
// fall_ctrl: active-piece controller for a falling-block board.
//
// Takes a spawn piece, asks an external checker whether it fits, then moves
// the piece on gravity ticks and left/right/down requests.  Every move is
// proposed as a candidate and checked before it is committed.  When a piece
// can no longer fall, the block asks the board to absorb it.
//
// Ports
//   clk                  single clock, all state changes on posedge
//   start                asynchronous active-high reset
//   sp_dot1..4, sp_index spawn piece cells {x[9:5], y[4:0]} and type
//   mv_left/right/down   one-cycle move request pulses (honoured in PLAY only)
//   chk_req, cand_dot1..4  collision check request and candidate cells
//   chk_ack, chk_ok      check done / candidate free (chk_ok valid with chk_ack)
//   cur_dot1..4, cur_index active piece
//   update               one-cycle pulse asking for the next spawn piece
//   lock_req, lock_ack   write cur_* into the board / write done
//   gameover             spawn piece did not fit; held until reset
//   pieces               locked piece count, saturating at 16'hFFFF
//
// state     | meaning
// ----------+--------------------------------------------------------------
// SPAWN     | latch spawn piece into cur, pulse update
// SPAWN_CHK | check that the spawn piece fits; no fit ends the game
// PLAY      | wait for gravity or a move request
// MOVE_CHK  | candidate move under check
// LOCK      | piece resting; wait for the board to absorb it
// OVER      | game ended, absorbing until reset

module fall_ctrl #(
    parameter int BOARD_W  = 10,
    parameter int BOARD_H  = 20,
    parameter int GRAV_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        start,
    input  logic [9:0]  sp_dot1,
    input  logic [9:0]  sp_dot2,
    input  logic [9:0]  sp_dot3,
    input  logic [9:0]  sp_dot4,
    input  logic [2:0]  sp_index,
    input  logic        mv_left,
    input  logic        mv_right,
    input  logic        mv_down,
    output logic        chk_req,
    output logic [9:0]  cand_dot1,
    output logic [9:0]  cand_dot2,
    output logic [9:0]  cand_dot3,
    output logic [9:0]  cand_dot4,
    input  logic        chk_ack,
    input  logic        chk_ok,
    output logic [9:0]  cur_dot1,
    output logic [9:0]  cur_dot2,
    output logic [9:0]  cur_dot3,
    output logic [9:0]  cur_dot4,
    output logic [2:0]  cur_index,
    output logic        update,
    output logic        lock_req,
    input  logic        lock_ack,
    output logic        gameover,
    output logic [15:0] pieces
);

    localparam int               CNT_W    = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GRAV_DIV - 1);
    localparam logic [4:0]       X_MAX    = 5'(BOARD_W - 1);
    localparam logic [4:0]       Y_MAX    = 5'(BOARD_H - 1);

    typedef enum logic [2:0] {
        SPAWN,
        SPAWN_CHK,
        PLAY,
        MOVE_CHK,
        LOCK,
        OVER
    } state_t;

    state_t state_q, state_nxt;

    logic [3:0][9:0] sp_cells;
    logic [3:0][9:0] cur_q, cur_nxt;
    logic [3:0][9:0] cand_q, cand_nxt;
    logic [3:0][9:0] cells_down, cells_left, cells_right;
    logic [2:0]      idx_q, idx_nxt;
    logic            chk_req_q, chk_req_nxt;
    logic            lock_req_q, lock_req_nxt;
    logic            update_q, update_nxt;
    logic            over_q, over_nxt;
    logic            move_down_q, move_down_nxt;
    logic [15:0]     pieces_q, pieces_nxt;

    logic [CNT_W-1:0] grav_cnt_q;
    logic             grav_pend_q;
    logic             grav_active;
    logic             grav_wrap;
    logic             grav_clr;

    logic at_left, at_right, at_bottom;
    logic ack;

    assign sp_cells = {sp_dot4, sp_dot3, sp_dot2, sp_dot1};

    // An ack is only meaningful while our request is up; stray acks are dropped.
    assign ack = chk_ack & chk_req_q;

    assign grav_active = (state_q == PLAY) || (state_q == MOVE_CHK);
    assign grav_wrap   = grav_active && (grav_cnt_q == CNT_LAST);

    // Shifted copies of the active piece.  Each is only used after the matching
    // edge test passed, so no 5-bit field can wrap.
    always_comb begin : shift_cells
        at_left     = 1'b0;
        at_right    = 1'b0;
        at_bottom   = 1'b0;
        cells_down  = '0;
        cells_left  = '0;
        cells_right = '0;
        for (int i = 0; i < 4; i++) begin
            if (cur_q[i][9:5] == 5'd0)  at_left   = 1'b1;
            if (cur_q[i][9:5] == X_MAX) at_right  = 1'b1;
            if (cur_q[i][4:0] == Y_MAX) at_bottom = 1'b1;
            cells_down[i]  = {cur_q[i][9:5], cur_q[i][4:0] + 5'd1};
            cells_left[i]  = {cur_q[i][9:5] - 5'd1, cur_q[i][4:0]};
            cells_right[i] = {cur_q[i][9:5] + 5'd1, cur_q[i][4:0]};
        end
    end

    always_ff @(posedge clk or posedge start) begin : state_reg
        if (start) state_q <= SPAWN;
        else       state_q <= state_nxt;
    end

    always_comb begin : fsm_next
        state_nxt     = state_q;
        cur_nxt       = cur_q;
        cand_nxt      = cand_q;
        idx_nxt       = idx_q;
        chk_req_nxt   = chk_req_q;
        lock_req_nxt  = lock_req_q;
        update_nxt    = 1'b0;
        over_nxt      = over_q;
        move_down_nxt = move_down_q;
        pieces_nxt    = pieces_q;
        grav_clr      = 1'b0;

        unique case (state_q)
            SPAWN: begin
                cur_nxt     = sp_cells;
                cand_nxt    = sp_cells;
                idx_nxt     = sp_index;
                update_nxt  = 1'b1;
                chk_req_nxt = 1'b1;
                state_nxt   = SPAWN_CHK;
            end

            SPAWN_CHK: begin
                if (ack) begin
                    chk_req_nxt = 1'b0;
                    if (chk_ok) begin
                        state_nxt = PLAY;
                    end else begin
                        over_nxt  = 1'b1;
                        state_nxt = OVER;
                    end
                end
            end

            PLAY: begin
                // A down request also services a pending gravity tick, so
                // both collapse into one move.
                if (grav_pend_q || mv_down) begin
                    grav_clr = 1'b1;
                    if (at_bottom) begin
                        lock_req_nxt = 1'b1;
                        state_nxt    = LOCK;
                    end else begin
                        cand_nxt      = cells_down;
                        move_down_nxt = 1'b1;
                        chk_req_nxt   = 1'b1;
                        state_nxt     = MOVE_CHK;
                    end
                end else if (mv_left) begin
                    if (!at_left) begin
                        cand_nxt      = cells_left;
                        move_down_nxt = 1'b0;
                        chk_req_nxt   = 1'b1;
                        state_nxt     = MOVE_CHK;
                    end
                end else if (mv_right) begin
                    if (!at_right) begin
                        cand_nxt      = cells_right;
                        move_down_nxt = 1'b0;
                        chk_req_nxt   = 1'b1;
                        state_nxt     = MOVE_CHK;
                    end
                end
            end

            MOVE_CHK: begin
                if (ack) begin
                    chk_req_nxt = 1'b0;
                    if (chk_ok) begin
                        cur_nxt   = cand_q;
                        state_nxt = PLAY;
                    end else if (move_down_q) begin
                        lock_req_nxt = 1'b1;
                        state_nxt    = LOCK;
                    end else begin
                        state_nxt = PLAY;
                    end
                end
            end

            LOCK: begin
                if (lock_ack) begin
                    lock_req_nxt = 1'b0;
                    if (pieces_q != 16'hFFFF) pieces_nxt = pieces_q + 16'd1;
                    state_nxt = SPAWN;
                end
            end

            OVER: begin
                chk_req_nxt  = 1'b0;
                lock_req_nxt = 1'b0;
                over_nxt     = 1'b1;
            end

            default: state_nxt = SPAWN;
        endcase
    end

    always_ff @(posedge clk or posedge start) begin : data_reg
        if (start) begin
            cur_q       <= '0;
            cand_q      <= '0;
            idx_q       <= '0;
            chk_req_q   <= 1'b0;
            lock_req_q  <= 1'b0;
            update_q    <= 1'b0;
            over_q      <= 1'b0;
            move_down_q <= 1'b0;
            pieces_q    <= '0;
        end else begin
            cur_q       <= cur_nxt;
            cand_q      <= cand_nxt;
            idx_q       <= idx_nxt;
            chk_req_q   <= chk_req_nxt;
            lock_req_q  <= lock_req_nxt;
            update_q    <= update_nxt;
            over_q      <= over_nxt;
            move_down_q <= move_down_nxt;
            pieces_q    <= pieces_nxt;
        end
    end

    // Gravity divider holds its count outside PLAY/MOVE_CHK.  A tick that
    // lands in the same cycle PLAY services the flag re-arms it.
    always_ff @(posedge clk or posedge start) begin : grav_reg
        if (start) begin
            grav_cnt_q  <= '0;
            grav_pend_q <= 1'b0;
        end else begin
            if (grav_active) begin
                if (grav_wrap) grav_cnt_q <= '0;
                else           grav_cnt_q <= grav_cnt_q + CNT_W'(1);
            end
            if (grav_wrap)     grav_pend_q <= 1'b1;
            else if (grav_clr) grav_pend_q <= 1'b0;
        end
    end

    assign chk_req   = chk_req_q;
    assign lock_req  = lock_req_q;
    assign update    = update_q;
    assign gameover  = over_q;
    assign pieces    = pieces_q;
    assign cur_index = idx_q;
    assign cur_dot1  = cur_q[0];
    assign cur_dot2  = cur_q[1];
    assign cur_dot3  = cur_q[2];
    assign cur_dot4  = cur_q[3];
    assign cand_dot1 = cand_q[0];
    assign cand_dot2 = cand_q[1];
    assign cand_dot3 = cand_q[2];
    assign cand_dot4 = cand_q[3];

endmodule
